// File: rtl/baud_pkg.sv
// Shared definitions for the fractional baud tick generator: default-divisor
// arithmetic, the minimum integer divisor and the legal oversample ratios.
package baud_pkg;

   localparam int MIN_DIV_INT = 2;
   localparam int DIV_INT_W   = 16;
   localparam int DIV_FRAC_W  = 8;

   // Divisor bundle at the default widths, for blocks that carry a divisor around.
   typedef struct packed {
      logic [DIV_INT_W-1:0]  div_int;
      logic [DIV_FRAC_W-1:0] div_frac;
   } baud_div_t;

   // Fixed-point divisor (int.frac with frac_w fraction bits), computed in 64 bits
   // so that CLK_FREQ << FRAC_W cannot overflow.
   function automatic logic [63:0] default_div_fixed(input logic [63:0] clk_freq,
                                                     input logic [63:0] baud_rate,
                                                     input logic [63:0] oversample,
                                                     input int          frac_w);
      return (clk_freq << frac_w) / (baud_rate * oversample);
   endfunction

   function automatic bit oversample_legal(input int os);
      return (os == 4) || (os == 8) || (os == 16);
   endfunction

endpackage

// File: rtl/baud_gen_frac.sv
// Fractional baud tick generator: os/mid/bit ticks from clk / (div_int + div_frac/2^FRAC_W).
// Define BAUD_GEN_FRAC_DITHER_EN to include the fractional accumulator; otherwise integer division only.
module baud_gen_frac
   import baud_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int INT_W      = 16,
   parameter int FRAC_W     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              resync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [INT_W-1:0]  cfg_div_int,
   input  logic [FRAC_W-1:0] cfg_div_frac,
   output logic              os_tick,
   output logic              mid_tick,
   output logic              bit_tick
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
   localparam logic [63:0]      DEF_FIXED = default_div_fixed(64'(CLK_FREQ), 64'(BAUD_RATE),
                                                              64'(OVERSAMPLE), FRAC_W);
   localparam logic [INT_W-1:0] DEF_INT   = DEF_FIXED[FRAC_W +: INT_W];

   if (!oversample_legal(OVERSAMPLE)) begin : g_bad_oversample
      $error("baud_gen_frac: OVERSAMPLE must be 4, 8 or 16");
   end

   logic [INT_W-1:0] r_cnt;
   logic [INT_W-1:0] r_act_int;
   logic [INT_W-1:0] r_sh_int;
   logic [OS_W-1:0]  r_os_cnt;
   logic             r_pending;
   logic             r_cfg_ready;
   logic             r_os_tick;
   logic             r_mid_tick;
   logic             r_bit_tick;

   logic [INT_W-1:0] w_cfg_int;
   logic [INT_W-1:0] w_lim;
   logic             w_carry;
   logic             w_accept;
   logic             w_resync;
   logic             w_boundary;
   logic             w_load;
   logic             w_direct;

   // Handshake: a divisor transfers on any posedge where cfg_valid && cfg_ready.
   // cfg_ready is low while a shadow value waits for its period boundary and for
   // one further cycle after it has been copied into the active divisor.
   assign w_accept   = cfg_valid & r_cfg_ready;
   assign w_resync   = enable & resync;
   assign w_boundary = enable & ~resync & (r_cnt == w_lim);
   assign w_load     = r_pending & (w_boundary | w_resync);
   assign w_direct   = w_accept & w_resync;

   assign w_cfg_int  = (cfg_div_int < INT_W'(MIN_DIV_INT)) ? INT_W'(MIN_DIV_INT) : cfg_div_int;
   assign w_lim      = r_act_int - INT_W'(1) + INT_W'(w_carry);

`ifdef BAUD_GEN_FRAC_DITHER_EN
   localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_FIXED[FRAC_W-1:0];

   logic [FRAC_W-1:0] r_frac_acc;
   logic [FRAC_W-1:0] r_act_frac;
   logic [FRAC_W-1:0] r_sh_frac;
   logic [FRAC_W:0]   w_frac_sum;

   // The carry of the pending accumulation stretches the current period by one clk.
   assign w_frac_sum = {1'b0, r_frac_acc} + {1'b0, r_act_frac};
   assign w_carry    = w_frac_sum[FRAC_W];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_frac_acc <= '0;
         r_act_frac <= DEF_FRAC;
         r_sh_frac  <= DEF_FRAC;
      end else begin
         if (w_accept && !w_resync) begin
            r_sh_frac <= cfg_div_frac;
         end
         if (w_direct) begin
            r_act_frac <= cfg_div_frac;
         end else if (w_load) begin
            r_act_frac <= r_sh_frac;
         end
         if (w_resync) begin
            r_frac_acc <= '0;
         end else if (w_boundary) begin
            r_frac_acc <= w_frac_sum[FRAC_W-1:0];
         end
      end
   end
`else
   logic w_unused_frac;

   assign w_carry       = 1'b0;
   assign w_unused_frac = ^cfg_div_frac;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_os_cnt    <= '0;
         r_act_int   <= DEF_INT;
         r_sh_int    <= DEF_INT;
         r_pending   <= 1'b0;
         r_cfg_ready <= 1'b1;
         r_os_tick   <= 1'b0;
         r_mid_tick  <= 1'b0;
         r_bit_tick  <= 1'b0;
      end else begin
         r_cfg_ready <= ~w_accept & ~r_pending;

         if (w_accept && !w_resync) begin
            r_sh_int  <= w_cfg_int;
            r_pending <= 1'b1;
         end else if (w_load) begin
            r_pending <= 1'b0;
         end

         // Reload only at a period edge or a resync, so no period is cut or stretched.
         if (w_direct) begin
            r_act_int <= w_cfg_int;
         end else if (w_load) begin
            r_act_int <= r_sh_int;
         end

         r_os_tick  <= w_boundary;
         r_mid_tick <= w_boundary & (r_os_cnt == OS_MID);
         r_bit_tick <= w_boundary & (r_os_cnt == OS_LAST);

         if (w_resync) begin
            r_cnt    <= '0;
            r_os_cnt <= '0;
         end else if (w_boundary) begin
            r_cnt    <= '0;
            r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
         end else if (enable) begin
            r_cnt <= r_cnt + INT_W'(1);
         end
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign os_tick   = r_os_tick;
   assign mid_tick  = r_mid_tick;
   assign bit_tick  = r_bit_tick;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: per-cycle behavioural model plus directed timing checks.
// Expectations follow BAUD_GEN_FRAC_DITHER_EN when it is defined for the build.
module tb_baud_gen_frac;

   localparam int OS  = 16;
   localparam int FW  = 8;
   localparam int IW  = 16;
   // 50 MHz / (9600 * 16) = 325 + 133/256
   localparam int DEF_INT  = 325;
   localparam int DEF_FRAC = 133;
`ifdef BAUD_GEN_FRAC_DITHER_EN
   localparam bit DITHER = 1'b1;
`else
   localparam bit DITHER = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          resync;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [IW-1:0] cfg_div_int;
   logic [FW-1:0] cfg_div_frac;
   logic          os_tick;
   logic          mid_tick;
   logic          bit_tick;

   baud_gen_frac dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .resync       (resync),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_div_int  (cfg_div_int),
      .cfg_div_frac (cfg_div_frac),
      .os_tick      (os_tick),
      .mid_tick     (mid_tick),
      .bit_tick     (bit_tick)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int os_q[$];
   int mid_q[$];
   int bit_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
      end
   endtask

   // Model: the divisor is a rational number; each period lasts its integer part
   // plus one clk whenever the running fractional sum crosses a whole unit.
   int m_int, m_frac, m_sh_int, m_sh_frac, m_acc, m_elapsed, m_len, m_ticks;
   bit m_pending, m_ready, m_os, m_mid, m_bit, m_live = 1'b0;

   function automatic int clamp_div(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   function automatic int period_len(input int d_int, input int d_frac, input int acc);
      if (DITHER) return d_int + (((acc + d_frac) >= (1 << FW)) ? 1 : 0);
      return d_int;
   endfunction

   always @(posedge clk) begin
      bit acc_now;
      bit pend_before;
      cyc++;
      if (!reset_n) begin
         m_int = DEF_INT; m_frac = DEF_FRAC; m_sh_int = DEF_INT; m_sh_frac = DEF_FRAC;
         m_acc = 0; m_elapsed = 0; m_ticks = 0; m_pending = 1'b0; m_ready = 1'b1;
         m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0; m_live = 1'b1;
      end else if (m_live) begin
         acc_now     = cfg_valid && m_ready;
         pend_before = m_pending;
         m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
         if (enable && resync) begin
            if (acc_now) begin
               m_int = clamp_div(int'(cfg_div_int)); m_frac = int'(cfg_div_frac);
            end else if (m_pending) begin
               m_int = m_sh_int; m_frac = m_sh_frac; m_pending = 1'b0;
            end
            m_elapsed = 0; m_acc = 0; m_ticks = 0;
         end else begin
            if (enable) begin
               m_elapsed++;
               if (m_elapsed == m_len) begin
                  m_os  = 1'b1;
                  m_mid = (m_ticks % OS) == (OS / 2 - 1);
                  m_bit = (m_ticks % OS) == (OS - 1);
                  m_ticks++;
                  m_acc     = (m_acc + m_frac) % (1 << FW);
                  m_elapsed = 0;
                  if (m_pending) begin
                     m_int = m_sh_int; m_frac = m_sh_frac; m_pending = 1'b0;
                  end
               end
            end
            if (acc_now) begin
               m_sh_int = clamp_div(int'(cfg_div_int)); m_sh_frac = int'(cfg_div_frac);
               m_pending = 1'b1;
            end
         end
         m_ready = !acc_now && !pend_before;
      end
      m_len = period_len(m_int, m_frac, m_acc);
      #1;
      if (m_live) begin
         check("os_tick", os_tick, m_os);
         check("mid_tick", mid_tick, m_mid);
         check("bit_tick", bit_tick, m_bit);
         check("cfg_ready", cfg_ready, m_ready);
         if (os_tick === 1'b1) os_q.push_back(cyc);
         if (mid_tick === 1'b1) mid_q.push_back(cyc);
         if (bit_tick === 1'b1) bit_q.push_back(cyc);
      end
   end

   function automatic int q_at(input int sel, input int idx);
      int v;
      v = -1;
      case (sel)
         0: if (idx < os_q.size()) v = os_q[idx];
         1: if (idx < mid_q.size()) v = mid_q[idx];
         default: if (idx < bit_q.size()) v = bit_q[idx];
      endcase
      return v;
   endfunction

   task automatic wait_until(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic clear_qs();
      os_q.delete(); mid_q.delete(); bit_q.delete();
   endtask

   // Returns r = number of the posedge that applies the resync.
   task automatic do_resync(input bit with_cfg, input int di, input int df, output int r);
      @(negedge clk);
      resync = 1'b1;
      if (with_cfg) begin
         cfg_valid = 1'b1; cfg_div_int = IW'(di); cfg_div_frac = FW'(df);
      end
      clear_qs();
      r = cyc + 1;
      @(negedge clk);
      resync = 1'b0; cfg_valid = 1'b0;
   endtask

   task automatic cfg_send(input int di, input int df);
      int n;
      n = 0;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_div_int = IW'(di); cfg_div_frac = FW'(df);
      while (cfg_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("cfg_accept_timeout", 32'(n), 32'd0);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   initial begin
      int x, r, r0;
      reset_n = 1'b0; enable = 1'b1; resync = 1'b0; cfg_valid = 1'b0;
      cfg_div_int = '0; cfg_div_frac = '0;
      repeat (3) @(negedge clk);
      check("rst_os_tick", os_tick, 1'b0);
      check("rst_bit_tick", bit_tick, 1'b0);
      check("rst_cfg_ready", cfg_ready, 1'b1);

      // 1: default divisor straight out of reset
      x = cyc;
      reset_n = 1'b1;
      wait_until(x + 10800);
      check("t1_first_os", q_at(0, 0) - x, 325);
      check("t1_first_mid", q_at(1, 0) - x, DITHER ? 2604 : 2600);
      check("t1_first_bit", q_at(2, 0) - x, DITHER ? 5208 : 5200);
      check("t1_span_32", q_at(0, 32) - q_at(0, 0), DITHER ? 10417 : 10400);

      // 2: 4 + 128/256 from a clean phase
      do_resync(1'b1, 4, 128, r);
      wait_until(r + 150);
      check("t2_os1", q_at(0, 0) - r, 4);
      check("t2_os2", q_at(0, 1) - r, DITHER ? 9 : 8);
      check("t2_os3", q_at(0, 2) - r, DITHER ? 13 : 12);
      check("t2_os4", q_at(0, 3) - r, DITHER ? 18 : 16);
      check("t2_mid1", q_at(1, 0) - r, DITHER ? 36 : 32);
      check("t2_bit1", q_at(2, 0) - r, DITHER ? 72 : 64);
      check("t2_bit_gap", q_at(2, 1) - q_at(2, 0), DITHER ? 72 : 64);

      // 3: reload 10/0 in the middle of a period
      do_resync(1'b0, 0, 0, r);
      cfg_send(10, 0);
      @(negedge clk);
      check("t3_ready_pend", cfg_ready, 1'b0);
      @(negedge clk);
      check("t3_ready_load", cfg_ready, 1'b0);
      @(negedge clk);
      check("t3_ready_back", cfg_ready, 1'b1);
      wait_until(r + 30);
      check("t3_os_old", q_at(0, 0) - r, 4);
      check("t3_os_new1", q_at(0, 1) - r, 14);
      check("t3_os_new2", q_at(0, 2) - r, 24);

      // 4: resync on a period boundary in mid-bit
      do_resync(1'b1, 4, 0, r0);
      wait_until(r0 + 18);
      do_resync(1'b0, 0, 0, r);
      check("t4_resync_edge", r - r0, 20);
      check("t4_no_tick", os_tick, 1'b0);
      wait_until(r + 70);
      check("t4_first_os", q_at(0, 0) - r, 4);
      check("t4_first_mid", q_at(1, 0) - r, 32);
      check("t4_first_bit", q_at(2, 0) - r, 64);

      // 5: 50-clk freeze inside a 10-clk period
      do_resync(1'b1, 10, 0, r);
      wait_until(r + 2);
      enable = 1'b0;
      wait_until(r + 52);
      enable = 1'b1;
      wait_until(r + 65);
      check("t5_stretched", q_at(0, 0) - r, 60);
      check("t5_count", 32'(os_q.size()), 32'd1);

      // 6: clamp 1 -> 2, then reset while a reload is pending
      do_resync(1'b1, 1, 0, r);
      wait_until(r + 7);
      check("t6_os1", q_at(0, 0) - r, 2);
      check("t6_os2", q_at(0, 1) - r, 4);
      check("t6_os3", q_at(0, 2) - r, 6);
      enable = 1'b0;
      cfg_send(50, 0);
      @(negedge clk);
      check("t6_pending", cfg_ready, 1'b0);
      enable = 1'b1;
      reset_n = 1'b0;
      clear_qs();
      @(negedge clk);
      check("t6_rst_os", os_tick, 1'b0);
      check("t6_rst_ready", cfg_ready, 1'b1);
      x = cyc;
      reset_n = 1'b1;
      wait_until(x + 330);
      check("t6_default_back", q_at(0, 0) - x, 325);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
